// File: rtl/dcache_if.sv
// Request and response structs plus the core/memory-facing bundle of the L1 data cache.
// The slave modport is the cache's view; the master modport is the core and memory side.
package dcache_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned LINE_W = 128;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              size;
    logic              is_store;
    logic [ACC_W-1:0]  data;
  } dcache_request_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              is_store;
    logic [LINE_W-1:0] data;
  } memory_request_t;
endpackage

interface dcache_if;
  import dcache_pkg::*;

  logic                      dcache_ready;
  logic                      xcpt_bus_error;
  logic                      req_valid;
  dcache_request_t           req_info;
  logic                      rsp_valid;
  logic [ACC_W-1:0]          rsp_data;
  logic                      req_valid_miss;
  memory_request_t           req_info_miss;
  logic [LINE_W-1:0]         rsp_data_miss;
  logic                      rsp_bus_error;
  logic                      rsp_valid_miss;

  modport slave (
    output dcache_ready, xcpt_bus_error, rsp_valid, rsp_data, req_valid_miss, req_info_miss,
    input  req_valid, req_info, rsp_data_miss, rsp_bus_error, rsp_valid_miss
  );

  modport master (
    input  dcache_ready, xcpt_bus_error, rsp_valid, rsp_data, req_valid_miss, req_info_miss,
    output req_valid, req_info, rsp_data_miss, rsp_bus_error, rsp_valid_miss
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped write-back write-allocate L1 data cache: same-cycle hits, misses stall via
// dcache_ready while a dirty victim is written back and the line is refilled.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned DCACHE_NUM_LINES    = 4,
  parameter int unsigned DCACHE_LINE_WIDTH   = LINE_W,
  parameter int unsigned DCACHE_MAX_ACC_SIZE = ACC_W,
  parameter int unsigned ADDR_WIDTH          = ADDR_W
) (
  input  logic    clock,
  input  logic    reset,
  dcache_if.slave bus
);
  localparam int unsigned OFF_W    = $clog2(DCACHE_LINE_WIDTH / 8);
  localparam int unsigned IDX_W    = $clog2(DCACHE_NUM_LINES);
  localparam int unsigned TAG_W    = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int unsigned WSEL_LSB = $clog2(DCACHE_MAX_ACC_SIZE / 8);
  localparam int unsigned SEL_W    = OFF_W + 3;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_COMPLETE} state_t;

  state_t                         state_q;
  logic [DCACHE_NUM_LINES-1:0]    valid_q;
  logic [DCACHE_NUM_LINES-1:0]    dirty_q;
  logic [TAG_W-1:0]               tag_q  [DCACHE_NUM_LINES];
  logic [DCACHE_LINE_WIDTH-1:0]   line_q [DCACHE_NUM_LINES];
  dcache_request_t                req_q;
  logic                           ready_q;
  logic                           mreq_vld_q;
  memory_request_t                mreq_q;
  logic                           cmpl_q;
  logic                           xcpt_q;
  logic [DCACHE_MAX_ACC_SIZE-1:0] cmpl_data_q;

  function automatic logic [SEL_W-1:0] word_pos(input logic [OFF_W-1:0] off);
    return {off[OFF_W-1:WSEL_LSB], {(WSEL_LSB + 3){1'b0}}};
  endfunction

  function automatic logic [SEL_W-1:0] byte_pos(input logic [OFF_W-1:0] off);
    return {off, 3'b000};
  endfunction

  // Word accesses ignore the sub-word offset bits; byte loads are zero-extended.
  function automatic logic [DCACHE_MAX_ACC_SIZE-1:0] load_data(
    input logic [DCACHE_LINE_WIDTH-1:0] line, input logic [OFF_W-1:0] off, input logic size);
    logic [DCACHE_MAX_ACC_SIZE-1:0] r;
    r = '0;
    if (size) r = line[word_pos(off) +: DCACHE_MAX_ACC_SIZE];
    else      r[7:0] = line[byte_pos(off) +: 8];
    return r;
  endfunction

  function automatic logic [DCACHE_LINE_WIDTH-1:0] merge_line(
    input logic [DCACHE_LINE_WIDTH-1:0] line, input logic [OFF_W-1:0] off, input logic size,
    input logic [DCACHE_MAX_ACC_SIZE-1:0] wdata);
    logic [DCACHE_LINE_WIDTH-1:0] m;
    m = line;
    if (size) m[word_pos(off) +: DCACHE_MAX_ACC_SIZE] = wdata;
    else      m[byte_pos(off) +: 8] = wdata[7:0];
    return m;
  endfunction

  logic [TAG_W-1:0] req_tag, pend_tag;
  logic [IDX_W-1:0] req_idx, pend_idx;
  logic [OFF_W-1:0] req_off, pend_off;
  logic             lookup_hit;

  assign req_tag  = bus.req_info.addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = bus.req_info.addr[OFF_W +: IDX_W];
  assign req_off  = bus.req_info.addr[OFF_W-1:0];
  assign pend_tag = req_q.addr[ADDR_WIDTH-1 -: TAG_W];
  assign pend_idx = req_q.addr[OFF_W +: IDX_W];
  assign pend_off = req_q.addr[OFF_W-1:0];

  assign lookup_hit = (state_q == S_IDLE) && bus.req_valid && valid_q[req_idx] &&
                      (tag_q[req_idx] == req_tag);

  assign bus.dcache_ready   = ready_q;
  assign bus.rsp_valid      = lookup_hit || cmpl_q;
  assign bus.xcpt_bus_error = xcpt_q;
  assign bus.req_valid_miss = mreq_vld_q;
  assign bus.req_info_miss  = mreq_q;

  always_comb begin
    bus.rsp_data = '0;
    if (lookup_hit && !bus.req_info.is_store)
      bus.rsp_data = load_data(line_q[req_idx], req_off, bus.req_info.size);
    else if (cmpl_q)
      bus.rsp_data = cmpl_data_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int i = 0; i < DCACHE_NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        line_q[i] <= '0;
      end
      req_q       <= '0;
      ready_q     <= 1'b1;
      mreq_vld_q  <= 1'b0;
      mreq_q      <= '0;
      cmpl_q      <= 1'b0;
      xcpt_q      <= 1'b0;
      cmpl_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lookup_hit) begin
            if (bus.req_info.is_store) begin
              line_q[req_idx]  <= merge_line(line_q[req_idx], req_off, bus.req_info.size,
                                             bus.req_info.data);
              dirty_q[req_idx] <= 1'b1;
            end
          end else if (bus.req_valid) begin
            req_q      <= bus.req_info;
            ready_q    <= 1'b0;
            mreq_vld_q <= 1'b1;
            if (valid_q[req_idx] && dirty_q[req_idx]) begin
              state_q <= S_WRITEBACK;
              mreq_q  <= '{addr: {tag_q[req_idx], req_idx, {OFF_W{1'b0}}}, is_store: 1'b1,
                           data: line_q[req_idx]};
            end else begin
              state_q <= S_REFILL;
              mreq_q  <= '{addr: {req_tag, req_idx, {OFF_W{1'b0}}}, is_store: 1'b0, data: '0};
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.rsp_valid_miss) begin
            if (bus.rsp_bus_error) begin
              state_q     <= S_COMPLETE;
              mreq_vld_q  <= 1'b0;
              mreq_q      <= '0;
              cmpl_q      <= 1'b1;
              xcpt_q      <= 1'b1;
              cmpl_data_q <= '0;
            end else begin
              state_q <= S_REFILL;
              mreq_q  <= '{addr: {pend_tag, pend_idx, {OFF_W{1'b0}}}, is_store: 1'b0, data: '0};
            end
          end
        end
        S_REFILL: begin
          if (bus.rsp_valid_miss) begin
            state_q    <= S_COMPLETE;
            mreq_vld_q <= 1'b0;
            mreq_q     <= '0;
            cmpl_q     <= 1'b1;
            if (bus.rsp_bus_error) begin
              xcpt_q      <= 1'b1;
              cmpl_data_q <= '0;
            end else begin
              valid_q[pend_idx] <= 1'b1;
              dirty_q[pend_idx] <= req_q.is_store;
              tag_q[pend_idx]   <= pend_tag;
              // The pending store lands on top of the freshly refilled line.
              line_q[pend_idx]  <= req_q.is_store ?
                                   merge_line(bus.rsp_data_miss, pend_off, req_q.size, req_q.data) :
                                   bus.rsp_data_miss;
              cmpl_data_q       <= req_q.is_store ? '0 :
                                   load_data(bus.rsp_data_miss, pend_off, req_q.size);
            end
          end
        end
        default: begin
          state_q     <= S_IDLE;
          ready_q     <= 1'b1;
          cmpl_q      <= 1'b0;
          xcpt_q      <= 1'b0;
          cmpl_data_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: hits, clean and dirty misses, bus errors, ignored inputs, reset mid-miss.
module tb_dcache;
  import dcache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  dcache_if bus();

  dcache dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic [31:0] a, input logic sz, input logic st,
                        input logic [31:0] wd, input logic exp_hit, input logic [31:0] exp_rd);
    bus.req_valid = 1'b1;
    bus.req_info  = '{addr: a, size: sz, is_store: st, data: wd};
    @(negedge clk);
    check("acc_rsp_valid", bus.rsp_valid, exp_hit);
    if (exp_hit) check("acc_rsp_data", bus.rsp_data, st ? 32'h0 : exp_rd);
    tick();
    bus.req_valid = 1'b0;
    bus.req_info  = '0;
  endtask

  task automatic mem_serve(input logic [31:0] ea, input logic est, input logic [127:0] ewd,
                           input int lat, input logic [127:0] line, input logic err);
    int n = 0;
    @(negedge clk);
    while (!bus.req_valid_miss && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mreq_vld", bus.req_valid_miss, 1'b1);
    check("mreq_addr", bus.req_info_miss.addr, ea);
    check("mreq_is_store", bus.req_info_miss.is_store, est);
    if (est) check("mreq_wdata", bus.req_info_miss.data, ewd);
    check("ready_in_miss", bus.dcache_ready, 1'b0);
    repeat (lat) begin
      @(negedge clk);
      check("mreq_hold", {bus.req_valid_miss, bus.req_info_miss.addr}, {1'b1, ea});
    end
    bus.rsp_valid_miss = 1'b1;
    bus.rsp_data_miss  = line;
    bus.rsp_bus_error  = err;
    tick();
    bus.rsp_valid_miss = 1'b0;
    bus.rsp_data_miss  = '0;
    bus.rsp_bus_error  = 1'b0;
  endtask

  task automatic expect_complete(input logic [31:0] ed, input logic ex);
    @(negedge clk);
    check("cmpl_rsp_valid", bus.rsp_valid, 1'b1);
    check("cmpl_rsp_data", bus.rsp_data, ed);
    check("cmpl_xcpt", bus.xcpt_bus_error, ex);
    check("cmpl_ready", bus.dcache_ready, 1'b0);
    check("cmpl_mreq_vld", bus.req_valid_miss, 1'b0);
    tick();
    @(negedge clk);
    check("post_ready", bus.dcache_ready, 1'b1);
    check("post_xcpt", bus.xcpt_bus_error, 1'b0);
    tick();
  endtask

  localparam logic [127:0] L1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] L1M = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAA5AAA;
  localparam logic [127:0] L2 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] L3 = 128'h0C0C0C03_0C0C0C02_0C0C0C01_0C0C0C00;
  localparam logic [127:0] L4W = 128'h00000000_00000000_12345678_00000000;
  localparam logic [127:0] L5 = 128'h5000000F_5000000E_5000000D_5000000C;
  localparam logic [127:0] L5M = 128'h5000000F_5000000E_5000000D_50EE000C;
  localparam logic [127:0] L6 = 128'h63636363_62626262_61616161_60606060;
  localparam logic [127:0] L7 = 128'h73737373_72727272_71717171_70707070;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid      = 1'b0;
    bus.req_info       = '0;
    bus.rsp_valid_miss = 1'b0;
    bus.rsp_data_miss  = '0;
    bus.rsp_bus_error  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_ready", bus.dcache_ready, 1'b1);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_mreq_vld", bus.req_valid_miss, 1'b0);
    check("rst_xcpt", bus.xcpt_bus_error, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 32'h0);
    check("rst_mreq_info", bus.req_info_miss, '0);
    tick();

    // Clean miss then same-line hits and a byte store.
    access(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'h40, 1'b0, '0, 1, L1, 1'b0);
    expect_complete(32'hAAAAAAAA, 1'b0);
    access(32'h44, 1'b1, 1'b0, 32'h0, 1'b1, 32'hBBBBBBBB);
    access(32'h41, 1'b0, 1'b1, 32'h0000005A, 1'b1, 32'h0);
    access(32'h40, 1'b1, 1'b0, 32'h0, 1'b1, 32'hAAAA5AAA);
    access(32'h41, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000005A);
    access(32'h43, 1'b0, 1'b0, 32'h0, 1'b1, 32'h000000AA);

    // Dirty eviction: writeback of the merged line, then refill.
    access(32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'h40, 1'b1, L1M, 0, '0, 1'b0);
    mem_serve(32'h80, 1'b0, '0, 2, L2, 1'b0);
    expect_complete(32'h11111111, 1'b0);

    // Refill bus error leaves the old line in place; the retry misses again.
    access(32'hC0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'hC0, 1'b0, '0, 0, L3, 1'b1);
    expect_complete(32'h0, 1'b1);
    access(32'h84, 1'b1, 1'b0, 32'h0, 1'b1, 32'h22222222);
    access(32'hC8, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'hC0, 1'b0, '0, 0, L3, 1'b0);
    expect_complete(32'h0C0C0C02, 1'b0);

    // Store miss, then eviction carries the store data.
    access(32'h104, 1'b1, 1'b1, 32'h12345678, 1'b0, 32'h0);
    mem_serve(32'h100, 1'b0, '0, 1, '0, 1'b0);
    expect_complete(32'h0, 1'b0);
    access(32'h140, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'h100, 1'b1, L4W, 0, '0, 1'b0);
    mem_serve(32'h140, 1'b0, '0, 0, L5, 1'b0);
    expect_complete(32'h5000000C, 1'b0);

    // Writeback bus error keeps the dirty victim, which is written back again later.
    access(32'h142, 1'b0, 1'b1, 32'h000000EE, 1'b1, 32'h0);
    access(32'h140, 1'b1, 1'b0, 32'h0, 1'b1, 32'h50EE000C);
    access(32'h180, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'h140, 1'b1, L5M, 0, '0, 1'b1);
    expect_complete(32'h0, 1'b1);
    access(32'h140, 1'b1, 1'b0, 32'h0, 1'b1, 32'h50EE000C);
    access(32'h18C, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'h140, 1'b1, L5M, 0, '0, 1'b0);
    mem_serve(32'h180, 1'b0, '0, 1, L6, 1'b0);
    expect_complete(32'h63636363, 1'b0);

    // A request while stalled is ignored.
    access(32'h1C4, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    bus.req_valid = 1'b1;
    bus.req_info  = '{addr: 32'h1C4, size: 1'b1, is_store: 1'b1, data: 32'hFFFFFFFF};
    @(negedge clk);
    check("stall_rsp_valid", bus.rsp_valid, 1'b0);
    check("stall_ready", bus.dcache_ready, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    bus.req_info  = '0;
    mem_serve(32'h1C0, 1'b0, '0, 0, L7, 1'b0);
    expect_complete(32'h71717171, 1'b0);
    access(32'h1C4, 1'b1, 1'b0, 32'h0, 1'b1, 32'h71717171);

    // Spurious memory response in IDLE changes nothing.
    bus.rsp_valid_miss = 1'b1;
    bus.rsp_data_miss  = {4{32'hFFFFFFFF}};
    @(negedge clk);
    check("spur_rsp_valid", bus.rsp_valid, 1'b0);
    check("spur_mreq_vld", bus.req_valid_miss, 1'b0);
    check("spur_ready", bus.dcache_ready, 1'b1);
    tick();
    bus.rsp_valid_miss = 1'b0;
    bus.rsp_data_miss  = '0;
    @(negedge clk);
    check("spur_after_ready", bus.dcache_ready, 1'b1);
    tick();
    access(32'h1CC, 1'b1, 1'b0, 32'h0, 1'b1, 32'h73737373);

    // Reset in the middle of a miss abandons it and invalidates the cache.
    access(32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("pre_rst_mreq_vld", bus.req_valid_miss, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_mreq_vld", bus.req_valid_miss, 1'b0);
    check("midrst_ready", bus.dcache_ready, 1'b1);
    tick();
    access(32'h1C4, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    mem_serve(32'h1C0, 1'b0, '0, 0, L7, 1'b0);
    expect_complete(32'h71717171, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
